// File: rtl/sort3_pkg.sv
// sort3_pkg: shared types and constants for the 3-bit block sorter.
// Exports W (word width), N_MIN/N_MAX (legal block sizes), state_t, n_legal().
package sort3_pkg;

    localparam int W     = 3;
    localparam int N_MIN = 2;
    localparam int N_MAX = 8;

    typedef enum logic [1:0] {
        LOAD,
        SORT,
        DRAIN
    } state_t;

    function automatic bit n_legal(input int n);
        return (n >= N_MIN) && (n <= N_MAX);
    endfunction

endpackage

// File: rtl/sort3_ctrl_if.sv
// sort3_ctrl_if: input and output valid/ready streams of the sorter.
// master = source/consumer side, slave = sorter side.
interface sort3_ctrl_if;
    import sort3_pkg::*;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_last
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_last
    );

endinterface

// File: rtl/cmp3_core.sv
// cmp3_core: combinational 3-bit unsigned magnitude comparator.
// Ports: a, b in; equal, greater (a>b), less (a<b) out.
module cmp3_core
    import sort3_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         equal,
    output logic         greater,
    output logic         less
);

    assign equal   = (a == b);
    assign greater = (a > b);
    assign less    = (a < b);

endmodule

// File: rtl/sort3_ctrl.sv
// sort3_ctrl: loads N 3-bit words, bubble-sorts them in place with one
// shared comparator, then streams them out ascending.
// Ports: clk, rst (sync, active-high), bus (sort3_ctrl_if.slave), busy.
module sort3_ctrl
    import sort3_pkg::*;
#(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              rst,
    sort3_ctrl_if.slave       bus,
    output logic              busy
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef logic [IW-1:0] idx_t;

    localparam idx_t LAST = idx_t'(N - 1);
    localparam idx_t JMAX = idx_t'(N - 2);

    state_t       state;
    state_t       state_nx;
    logic [W-1:0] mem [N];
    idx_t         cnt;
    idx_t         j;
    idx_t         j1;
    idx_t         p;
    idx_t         k;
    logic         swapped;

    logic [W-1:0] a_val;
    logic [W-1:0] b_val;
    logic         eq;
    logic         gt;
    logic         lt;

    logic         ld_fire;
    logic         out_fire;
    logic         pass_end;
    logic         sort_done;
    logic         last_k;

    assign j1    = j + idx_t'(1);
    assign a_val = mem[j];
    assign b_val = mem[j1];

    cmp3_core u_cmp (
        .a       (a_val),
        .b       (b_val),
        .equal   (eq),
        .greater (gt),
        .less    (lt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_nx;
        end
    end

    // in_ready is masked by rst so no word is taken during reset.
    // A pass ends the sort if nothing moved in it, counting this cycle.
    always_comb begin
        state_nx      = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_last  = 1'b0;
        busy          = 1'b0;
        ld_fire       = 1'b0;
        out_fire      = 1'b0;
        pass_end      = 1'b0;
        sort_done     = 1'b0;
        last_k        = 1'b0;
        unique case (state)
            LOAD: begin
                bus.in_ready = !rst;
                ld_fire      = bus.in_valid && !rst;
                if (ld_fire && (cnt == LAST)) begin
                    state_nx = SORT;
                end
            end
            SORT: begin
                busy      = 1'b1;
                pass_end  = (j == JMAX);
                sort_done = pass_end &&
                            (!(swapped || gt) || (p == JMAX));
                if (sort_done) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                busy          = 1'b1;
                last_k        = (k == LAST);
                bus.out_valid = 1'b1;
                bus.out_data  = mem[k];
                bus.out_last  = last_k;
                out_fire      = bus.out_ready;
                if (out_fire && last_k) begin
                    state_nx = LOAD;
                end
            end
            default: begin
                state_nx = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            j       <= '0;
            p       <= '0;
            k       <= '0;
            swapped <= 1'b0;
            for (int i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (ld_fire) begin
                mem[cnt] <= bus.in_data;
                cnt      <= (cnt == LAST) ? '0 : cnt + idx_t'(1);
            end
            if (state == SORT) begin
                // Only strictly greater swaps, keeping equal words in order.
                if (gt) begin
                    mem[j]  <= b_val;
                    mem[j1] <= a_val;
                end
                if (pass_end) begin
                    j       <= '0;
                    swapped <= 1'b0;
                    p       <= sort_done ? '0 : p + idx_t'(1);
                end else begin
                    j       <= j + idx_t'(1);
                    swapped <= swapped | gt;
                end
            end
            if (out_fire) begin
                k <= last_k ? '0 : k + idx_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (n_legal(N));
            if (state == SORT) begin
                assert ($onehot({eq, gt, lt}));
            end
        end
    end

endmodule

// File: tb/tb_sort3_ctrl.sv
// tb_sort3_ctrl: scoreboard bench for sort3_ctrl (N=4).
// Expected sorted words are queued at load and checked on each output handshake.
module tb_sort3_ctrl;
    import sort3_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    sort3_ctrl_if bus ();

    sort3_ctrl #(.N(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] sb_q [$];

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Output monitor: scoreboard pop, hold rule, post-block ready.
    logic       hold_v     = 1'b0;
    logic [3:0] hold_val   = '0;
    logic       ready_next = 1'b0;
    logic [3:0] exp_w;

    always @(negedge clk) begin
        if (rst) begin
            hold_v     = 1'b0;
            ready_next = 1'b0;
        end else begin
            if (ready_next) begin
                chk("ready_after_last", bus.in_ready, 1);
                chk("idle_after_last", busy, 0);
                ready_next = 1'b0;
            end
            if (hold_v) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_word", {bus.out_last, bus.out_data}, hold_val);
            end
            hold_v = 1'b0;
            if (bus.out_valid && !bus.out_ready) begin
                hold_v   = 1'b1;
                hold_val = {bus.out_last, bus.out_data};
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_extra_word", sb_q.size(), 1);
                end else begin
                    exp_w = sb_q.pop_front();
                    chk("out_data", bus.out_data, exp_w[2:0]);
                    chk("out_last", bus.out_last, exp_w[3]);
                    if (bus.out_last) ready_next = 1'b1;
                end
            end
            if (bus.in_valid && busy) begin
                chk("no_accept_busy", bus.in_ready, 0);
            end
        end
    end

    // Call at posedge+#1; returns at posedge+#1 of the first SORT cycle.
    task automatic load4(input logic [2:0] v0, input logic [2:0] v1,
                         input logic [2:0] v2, input logic [2:0] v3,
                         input bit push);
        logic [2:0] v [4];
        logic [2:0] s [4];
        logic [2:0] t;
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
        s = v;
        for (int a = 1; a < 4; a++) begin
            for (int b = a; b > 0; b--) begin
                if (s[b-1] > s[b]) begin
                    t = s[b]; s[b] = s[b-1]; s[b-1] = t;
                end
            end
        end
        if (push) begin
            for (int i = 0; i < 4; i++) begin
                sb_q.push_back({(i == 3), s[i]});
            end
        end
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = v[i];
            @(negedge clk);
            chk("in_ready_load", bus.in_ready, 1);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    // Counts cycles from the last load handshake to first out_valid.
    // Returns at the negedge of the first DRAIN cycle.
    task automatic measure(input int exp_lat, input int exp_sort);
        int cyc = 1;
        int sc  = 0;
        bit seen = 1'b0;
        while (!seen && cyc <= 40) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
            end else begin
                if (busy) sc++;
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        chk("latency", cyc, exp_lat);
        chk("sort_cycles", sc, exp_sort);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_done", sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1);
        chk("post_rst_busy", busy, 0);
        @(posedge clk);
        #1;

        // Basic sort
        load4(3'd5, 3'd1, 3'd7, 3'd3, 1'b1);
        measure(10, 9);
        @(posedge clk);
        #1;
        wait_drain();

        // Already sorted: one pass
        load4(3'd0, 3'd2, 3'd4, 3'd6, 1'b1);
        measure(4, 3);
        @(posedge clk);
        #1;
        wait_drain();

        // Reverse order: N-1 passes
        load4(3'd7, 3'd6, 3'd5, 3'd4, 1'b1);
        measure(10, 9);
        @(posedge clk);
        #1;
        wait_drain();

        // Duplicates and extremes
        load4(3'd3, 3'd3, 3'd0, 3'd3, 1'b1);
        measure(10, 9);
        @(posedge clk);
        #1;
        wait_drain();
        load4(3'd7, 3'd0, 3'd7, 3'd0, 1'b1);
        measure(10, 9);
        @(posedge clk);
        #1;
        wait_drain();

        // Backpressure with stray in_valid pulses during DRAIN
        bus.out_ready = 1'b0;
        load4(3'd2, 3'd6, 3'd1, 3'd4, 1'b1);
        measure(10, 9);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = i[0];
            bus.in_data  = 3'd7;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        begin
            int t = 0;
            while (sb_q.size() != 0 && t < 100) begin
                bus.out_ready = ~bus.out_ready;
                @(posedge clk);
                #1;
                t++;
            end
        end
        chk("bp_drain_done", sb_q.size(), 0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset in the 2nd SORT cycle, then a clean block
        load4(3'd7, 3'd6, 3'd5, 3'd4, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", bus.in_ready, 1);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_out_data", bus.out_data, 0);
        @(posedge clk);
        #1;
        load4(3'd6, 3'd5, 3'd4, 3'd3, 1'b1);
        measure(10, 9);
        @(posedge clk);
        #1;
        wait_drain();
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
